muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations for the execute stage. The hazard unit holds the EX stage stalled while `busy` is high. The unit latches operands on `start` and computes MUL/MULH/MULHSU/MULHU with shift-add and DIV/DIVU/REM/REMU with restoring division, one bit per cycle. It then presents a one-cycle `done` pulse with the result and the destination register tag. A branch/jump flush can kill it mid-operation.

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle done pulse and flush.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_lat_q, rd_lat_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Operand decode at start: signedness, magnitudes and special cases
  logic            a_sgn, b_sgn, is_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    is_div   = op[2];
    a_mag    = (a_sgn && a[XLEN-1]) ? (XLEN'(0) - a) : a;
    b_mag    = (b_sgn && b[XLEN-1]) ? (XLEN'(0) - b) : b;
    div_zero = is_div && (b == XLEN'(0));
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == {XLEN{1'b1}});
  end

  // One iteration of each algorithm on the shared accumulator
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  logic [XLEN:0]   rem_ext;
  logic [XLEN:0]   div_trial;
  logic [AW-1:0]   div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, opnd_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[AW-1:1]};
    rem_ext   = acc_q[AW-1:XLEN-1];
    div_trial = rem_ext - {1'b0, opnd_q};
    div_next  = div_trial[XLEN] ? {rem_ext[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix and result select; divide keeps {rem, quot} in {hi, lo}
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = neg_q ? (AW'(0) - acc_q) : acc_q;
    quot_fix = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (XLEN'(0) - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN];
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[AW-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quot_fix;
      OP_REM, OP_REMU:               final_res = rem_fix;
      default:                       final_res = XLEN'(0);
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_lat_d   = rd_lat_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    result_d   = result_q;
    rd_out_d   = rd_out_q;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d      = op;
          rd_lat_d  = rd_in;
          cnt_d     = CW'(0);
          opnd_d    = is_div ? b_mag : a_mag;
          acc_d     = {XLEN'(0), (is_div ? a_mag : b_mag)};
          neg_d     = (op == OP_REM || op == OP_REMU) ? (a_sgn && a[XLEN-1])
                    : ((a_sgn && a[XLEN-1]) ^ (b_sgn && b[XLEN-1]));
          special_d = div_zero || div_ovf;
          if (div_zero) begin
            spec_res_d = op[1] ? a : {XLEN{1'b1}};
          end else begin
            spec_res_d = op[1] ? XLEN'(0) : a;
          end
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (special_q || (cnt_q == CW'(XLEN))) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = special_q ? spec_res_q : final_res;
          rd_out_d = rd_lat_q;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush abandons the operation and leaves the visible result alone
    if (kill) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      rd_lat_q   <= 5'd0;
      acc_q      <= AW'(0);
      opnd_q     <= XLEN'(0);
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= XLEN'(0);
      cnt_q      <= CW'(0);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= XLEN'(0);
      rd_out_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_lat_q   <= rd_lat_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32: arithmetic,
// special cases, latency, kill, ignored start and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    rd_in = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [4:0] rd,
                     input logic [31:0] exp, input int lat);
    int c;
    issue(o, x, y, rd);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(c);
    check({tag, "_latency"}, 32'(c), 32'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
    run("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    run("divu",   3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33);
    run("remu",   3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33);

    // Flush mid-divide: no done, previous result and tag survive
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_done", {31'b0, done}, 32'd0);
    check("kill_result", result, 32'd2);
    check("kill_rd", {27'b0, rd_out}, 32'd8);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("kill_no_done", 32'(seen), 32'd0);

    run("div0",   3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
    run("rem0",   3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        1);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);

    // Start pulsed during CALC is dropped
    issue(3'b101, 32'd100, 32'd7, 5'd14);
    repeat (5) @(posedge clk);
    issue(3'b000, 32'd1, 32'd1, 5'd15);
    wait_done(c);
    check("ign_result", result, 32'd14);
    check("ign_rd", {27'b0, rd_out}, 32'd14);
    @(posedge clk);
    #1;
    check("ign_idle", {31'b0, busy}, 32'd0);

    // Async reset between edges mid-CALC
    issue(3'b000, 32'd5, 32'd6, 5'd16);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("mul34", 3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
